// File: rtl/qif_neuron_array_if.sv
// Update/result stream bundle for qif_neuron_array: (ch, cur) in, (ch, v, spike) out.
// Both directions are valid/ready; master is the producer of updates.
interface qif_neuron_array_if #(
   parameter int WIDTH     = 8,
   parameter int N_NEURONS = 4
);
   localparam int CH_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

   logic                    in_valid;
   logic                    in_ready;
   logic [CH_W-1:0]         in_ch;
   logic signed [WIDTH-1:0] in_cur;
   logic                    out_valid;
   logic                    out_ready;
   logic [CH_W-1:0]         out_ch;
   logic signed [WIDTH-1:0] out_v;
   logic                    out_spike;

   modport master (
      output in_valid, in_ch, in_cur, out_ready,
      input  in_ready, out_valid, out_ch, out_v, out_spike
   );

   modport slave (
      input  in_valid, in_ch, in_cur, out_ready,
      output in_ready, out_valid, out_ch, out_v, out_spike
   );
endinterface

// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of QIF neurons over one squarer+adder datapath; one-cycle latency.
// One-deep output register: in_ready = !out_valid || out_ready. Refractory counters: QIF_REFRAC_EN.
// Purpose: per-channel membrane update; latency 1 cycle; backpressure stalls input while result unread.
module qif_neuron_array #(
   parameter int WIDTH     = 8,
   parameter int N_NEURONS = 4,
   parameter int V_TH      = 50,
   parameter int V_RESET   = -20,
   parameter int I_SHIFT   = 2,
   parameter int A_SHIFT   = 3,
   parameter int REFRAC    = 2
) (
   input logic              clk,
   input logic              rst_n,
   qif_neuron_array_if.slave bus
);
   localparam int CH_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int SW   = 2 * WIDTH + 2;

   localparam logic signed [WIDTH-1:0] V_TH_W    = V_TH[WIDTH-1:0];
   localparam logic signed [WIDTH-1:0] V_RESET_W = V_RESET[WIDTH-1:0];
   localparam logic [CH_W:0]           N_CMP     = N_NEURONS[CH_W:0];

   localparam logic signed [SW-1:0] SAT_HI = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_LO = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] V_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] V_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH-1:0] v_mem [N_NEURONS];

   logic                      accept;
   logic                      ch_ok;
   logic signed [WIDTH-1:0]   v_cur;
   logic signed [WIDTH-1:0]   cur_sh;
   logic signed [WIDTH-1:0]   v_sh;
   logic signed [2*WIDTH-1:0] v_sq;
   logic signed [SW-1:0]      sum;
   logic signed [WIDTH-1:0]   v_int;
   logic signed [WIDTH-1:0]   v_next;
   logic                      spike_next;

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   // Out-of-range channels are swallowed: accepted, but no state or result update.
   assign ch_ok        = ({1'b0, bus.in_ch} < N_CMP);
   assign v_cur        = v_mem[bus.in_ch];

   assign cur_sh = bus.in_cur >>> I_SHIFT;
   assign v_sh   = v_cur >>> A_SHIFT;
   assign v_sq   = v_sh * v_sh;
   assign sum    = {{(SW-WIDTH){v_cur[WIDTH-1]}}, v_cur}
                 + {{(SW-WIDTH){cur_sh[WIDTH-1]}}, cur_sh}
                 + {{(SW-2*WIDTH){v_sq[2*WIDTH-1]}}, v_sq};

   always_comb begin
      v_int = sum[WIDTH-1:0];
      if (sum > SAT_HI) begin
         v_int = V_MAX;
      end else if (sum < SAT_LO) begin
         v_int = V_MIN;
      end
   end

`ifdef QIF_REFRAC_EN
   localparam logic [3:0] REFRAC_W = REFRAC[3:0];

   logic [3:0] r_mem [N_NEURONS];
   logic [3:0] r_cur;
   logic [3:0] r_next;

   assign r_cur = r_mem[bus.in_ch];

   always_comb begin
      v_next     = v_int;
      spike_next = 1'b0;
      r_next     = r_cur;
      if (v_cur >= V_TH_W) begin
         v_next     = V_RESET_W;
         spike_next = 1'b1;
         r_next     = REFRAC_W;
      end else if (r_cur != 4'd0) begin
         // Refractory: the incoming current is consumed but has no effect.
         v_next = V_RESET_W;
         r_next = r_cur - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (accept && ch_ok) begin
         r_mem[bus.in_ch] <= r_next;
      end
   end
`else
   logic [3:0] refrac_unused;
   assign refrac_unused = REFRAC[3:0];

   always_comb begin
      v_next     = v_int;
      spike_next = 1'b0;
      if (v_cur >= V_TH_W) begin
         v_next     = V_RESET_W;
         spike_next = 1'b1;
      end
   end
`endif

   // State is written on the accept edge, so a same-channel update on the next cycle sees it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            v_mem[i] <= '0;
         end
         bus.out_valid <= 1'b0;
         bus.out_ch    <= '0;
         bus.out_v     <= '0;
         bus.out_spike <= 1'b0;
      end else begin
         if (accept && ch_ok) begin
            v_mem[bus.in_ch] <= v_next;
            bus.out_valid    <= 1'b1;
            bus.out_ch       <= bus.in_ch;
            bus.out_v        <= v_next;
            bus.out_spike    <= spike_next;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_qif_neuron_array.sv
// Scoreboard bench for qif_neuron_array: default-threshold instance plus a V_TH=127 instance for saturation.
module tb_qif_neuron_array;
   localparam int N      = 4;
   localparam int REFRAC = 2;

   typedef struct {
      int ch;
      int v;
      int sp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic final_chk = 1'b0;

   always #5 clk = ~clk;

   qif_neuron_array_if #(.WIDTH(8), .N_NEURONS(N)) bus  ();
   qif_neuron_array_if #(.WIDTH(8), .N_NEURONS(N)) sbus ();

   qif_neuron_array #(
      .WIDTH(8), .N_NEURONS(N), .V_TH(50), .V_RESET(-20),
      .I_SHIFT(2), .A_SHIFT(3), .REFRAC(REFRAC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   qif_neuron_array #(
      .WIDTH(8), .N_NEURONS(N), .V_TH(127), .V_RESET(-20),
      .I_SHIFT(2), .A_SHIFT(3), .REFRAC(REFRAC)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(sbus)
   );

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t eq [2][$];
   int   mv [2][N];
   int   mr [2][N];

   // ---------------- reference model ----------------
   function automatic int floor_div_pow2(input int x, input int sh);
      int d;
      int q;
      d = 1 << sh;
      q = x / d;
      if ((x % d) != 0 && x < 0) q = q - 1;
      return q;
   endfunction

   function automatic int clip8(input int x);
      if (x > 127)  return 127;
      if (x < -128) return -128;
      return x;
   endfunction

   function automatic int thresh(input int k);
      return (k == 0) ? 50 : 127;
   endfunction

   task automatic model_update(input int k, input int ch, input int cur);
      exp_t e;
      int   v;
      int   a;
      if (ch >= N) return;
      v    = mv[k][ch];
      e.ch = ch;
      e.sp = 0;
      if (v >= thresh(k)) begin
         e.v  = -20;
         e.sp = 1;
         mr[k][ch] = REFRAC;
      end
`ifdef QIF_REFRAC_EN
      else if (mr[k][ch] > 0) begin
         e.v = -20;
         mr[k][ch] = mr[k][ch] - 1;
      end
`endif
      else begin
         a   = floor_div_pow2(v, 3);
         e.v = clip8(v + floor_div_pow2(cur, 2) + a * a);
      end
      mv[k][ch] = e.v;
      eq[k].push_back(e);
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
   endtask

   task automatic monitor(input int k, input logic ov, input logic ordy, input logic irdy,
                          input int ch, input int v, input logic sp);
      exp_t e;
      chk($sformatf("in_ready[%0d]", k), int'(irdy), int'(!ov || ordy));
      if (ov) begin
         if (eq[k].size() == 0) begin
            chk($sformatf("unexpected_result[%0d] ch", k), ch, -1);
         end else begin
            e = eq[k][0];
            chk($sformatf("out_ch[%0d]", k), ch, e.ch);
            chk($sformatf("out_v[%0d] ch%0d", k, e.ch), v, e.v);
            chk($sformatf("out_spike[%0d] ch%0d", k, e.ch), int'(sp), e.sp);
            if (ordy) void'(eq[k].pop_front());
         end
      end else if (eq[k].size() != 0) begin
         chk($sformatf("missing_result[%0d] pending", k), 0, eq[k].size());
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            eq[k].delete();
            for (int i = 0; i < N; i++) begin
               mv[k][i] = 0;
               mr[k][i] = 0;
            end
         end
         chk("rst out_valid", int'(bus.out_valid), 0);
         chk("rst out_ch",    int'(bus.out_ch), 0);
         chk("rst out_v",     int'(bus.out_v), 0);
         chk("rst out_spike", int'(bus.out_spike), 0);
         chk("rst sat out_valid", int'(sbus.out_valid), 0);
      end else begin
         monitor(0, bus.out_valid, bus.out_ready, bus.in_ready,
                 int'(bus.out_ch), int'(bus.out_v), bus.out_spike);
         monitor(1, sbus.out_valid, sbus.out_ready, sbus.in_ready,
                 int'(sbus.out_ch), int'(sbus.out_v), sbus.out_spike);
         if (bus.in_valid && bus.in_ready)
            model_update(0, int'(bus.in_ch), int'(bus.in_cur));
         if (sbus.in_valid && sbus.in_ready)
            model_update(1, int'(sbus.in_ch), int'(sbus.in_cur));
         if (final_chk) begin
            chk("drained queue[0]", eq[0].size(), 0);
            chk("drained queue[1]", eq[1].size(), 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic put(input int ch, input int cur);
      bus.in_valid = 1'b1;
      bus.in_ch    = ch[1:0];
      bus.in_cur   = cur[7:0];
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_cycle();
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_ch      = 2'($urandom_range(0, 3));
      bus.in_cur     = 8'($urandom_range(0, 255));
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      sbus.in_valid  = ($urandom_range(0, 1) != 0);
      sbus.in_ch     = 2'($urandom_range(0, 3));
      sbus.in_cur    = 8'($urandom_range(0, 255));
      sbus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;  bus.in_ch = '0;  bus.in_cur = '0;  bus.out_ready = 1'b1;
      sbus.in_valid = 1'b0; sbus.in_ch = '0; sbus.in_cur = '0; sbus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Integration, spike, and post-spike behaviour on ch0; saturation drive on ch1 of dut_sat.
      for (int i = 0; i < 8; i++) begin
         sbus.in_valid = 1'b1;
         sbus.in_ch    = 2'd1;
         sbus.in_cur   = 8'sd127;
         put(0, 40);
      end
      bus.in_valid  = 1'b0;
      sbus.in_valid = 1'b0;
      @(posedge clk);
      #1;

      // Interleaved channels, one update per cycle.
      for (int i = 0; i < 16; i++) put(i % 4, 4 * (i % 4));
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;

      // Backpressure: hold the result for 3 cycles, then drain and accept on one edge.
      put(2, 20);
      bus.out_ready = 1'b0;
      bus.in_ch     = 2'd3;
      bus.in_cur    = 8'sd12;
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;

      for (int i = 0; i < 300; i++) randomize_cycle();

      // Async reset while a result is held.
      sbus.in_valid = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_ch     = 2'd1;
      bus.in_cur    = 8'sd30;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready  = 1'b1;
      sbus.out_ready = 1'b1;
      put(2, 8);
      bus.in_valid = 1'b0;

      for (int i = 0; i < 200; i++) randomize_cycle();

      bus.in_valid   = 1'b0;
      sbus.in_valid  = 1'b0;
      bus.out_ready  = 1'b1;
      sbus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      final_chk = 1'b1;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/qif_neuron_array.md
# qif_neuron_array

Time-multiplexed array of N quadratic integrate-and-fire (QIF) neurons sharing one arithmetic datapath. Each neuron's membrane potential and refractory state is held in an internal register file. A valid/ready stream of (channel, synaptic current) updates drives the array, and it emits one registered (channel, V_mem, spike) result per accepted update. It is the multi-channel, parametrised next generation of the single 8-bit QIF neuron and sits between the synapse accumulator and the spike router.

## Interface
- WIDTH, 8: signed width of membrane potential and synaptic current.
- N_NEURONS, 4: number of neurons; CH_W = max(1, clog2(N_NEURONS)).
- V_TH, 50: spike threshold (signed, WIDTH bits).
- V_RESET, -20: post-spike potential (signed, WIDTH bits).
- I_SHIFT, 2: arithmetic right shift applied to input current.
- A_SHIFT, 3: arithmetic right shift applied to V before squaring.
- REFRAC, 2: refractory length in accepted updates, 0..15. Only used with QIF_REFRAC_EN.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  update request.
- in_ready  out  1  array can accept an update.
- in_ch  in  CH_W  target neuron index.
- in_cur  in  WIDTH  signed synaptic current.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  CH_W  neuron index of the result.
- out_v  out  WIDTH  signed new membrane potential.
- out_spike  out  1  neuron fired on this update.

## Operation
- Accept occurs when in_valid && in_ready. in_ready = !out_valid || out_ready, which gives a one-deep output register with full throughput.
- On accept, with V = stored potential of in_ch:
  - If V >= V_TH (signed compare):
    - Vn = V_RESET; spike = 1.
    - Refractory counter loads REFRAC.
  - Else if the refractory counter is nonzero:
    - Vn = V_RESET; spike = 0; counter decrements.
    - in_cur is consumed and ignored.
  - Else:
    - Vn = sat(V + (in_cur>>>I_SHIFT) + (V>>>A_SHIFT)^2); spike = 0.
    - Sum is computed at 2*WIDTH+2 bits, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- All shifts are arithmetic (floor), e.g. -20>>>3 = -3.
- Vn and the counter are written to the register file on the accept edge. The result (in_ch, Vn, spike) is loaded into the out_* registers on the same edge.
- Back-to-back updates to the same channel need no stall: the state is written at the accept edge, so the next update reads the new value.
- in_ch >= N_NEURONS: the update is accepted and discarded. No state change and no output.
- out_* hold their value while out_valid && !out_ready.
- Reset (asynchronous, any time, including mid-stream):
  - All potentials and refractory counters = 0.
  - out_valid = 0, out_ch = 0, out_v = 0, out_spike = 0.
  - Any pending result is lost.

## Timing
- Latency: one cycle. A result is visible on out_* in the cycle after the accept edge.
- Throughput: one update per cycle while out_ready = 1.
- A simultaneous out drain and new accept is allowed: out_valid stays 1 and the new result replaces the old one.
- out_valid deasserts only on a drain edge without a new accept.
- in_ready is combinational from out_valid and out_ready. There is no other combinational in-to-out path.
- The datapath (one squarer plus an adder) must close in one cycle at WIDTH = 8.

## Configuration
- QIF_REFRAC_EN defined:
  - Per-neuron 4-bit refractory counters are present.
  - Behaviour is as above.
- QIF_REFRAC_EN undefined:
  - No counters are built and REFRAC is ignored.
  - The update after a spike integrates normally from V_RESET.

## Test plan
- Integration (defaults): reset, then ch0 receives in_cur = 40 four times. Required out_v = 10, 21, 35, 61 with out_spike = 0. A fifth update gives out_v = -20 with out_spike = 1.
- Refractory (QIF_REFRAC_EN, REFRAC = 2): continue the previous stream with in_cur = 40. The next two ch0 results are -20 with spike = 0. The third result is -20 + 10 + 9 = -1.
- Saturation (V_TH = 127): drive ch1 from V = 100 with in_cur = 100. Required out_v = 127 (sum 269 clipped), out_spike = 0.
- Channel isolation / back-to-back: interleave ch0..ch3 every cycle with in_cur = 4·ch. Each channel evolves independently with no bubble, and same-channel consecutive updates chain correctly.
- Backpressure: hold out_ready = 0 for 3 cycles after one accept. Required: in_ready = 0, out_* stable. Releasing out_ready with in_valid high drains and accepts in the same edge.
- Async reset mid-stream: assert rst_n = 0 between clock edges with out_valid = 1. Required: out_valid = 0 immediately and all V = 0. The first post-reset update with in_cur = 8 gives out_v = 2.
